// File: rtl/blu_pkg.sv
// Shared types and constants for the adder issue/retire controller and its
// result buffer.
package blu_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  // One buffered result; flags are resolved before the entry is written.
  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              co;
    logic              ovf;
    logic              zero;
    logic              neg;
    logic [TAG_W-1:0]  tag;
  } res_t;

  // Side-band that travels alongside an operation through the adder.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             a_sign;
    logic             b_sign;
  } sb_t;

  // Two's-complement overflow from the operand signs seen by the adder.
  function automatic logic calc_ovf(input logic a_sign,
                                    input logic b_sign,
                                    input logic s_sign);
    return (a_sign == b_sign) && (s_sign != a_sign);
  endfunction

endpackage

// File: rtl/blu_result_fifo.sv
// First-word-fall-through result buffer; the head entry is presented
// combinationally and reads as all-zero while the buffer is empty.
module blu_result_fifo
  import blu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  res_t                         wr_data,
  input  logic                         rd_en,
  output res_t                         rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  res_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          do_wr;
  logic          do_rd;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (do_wr && !do_rd) begin
      count_next = count_reg + CW'(1);
    end else if (!do_wr && do_rd) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Pointers are power-of-two wide so they wrap without extra logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/blu_add_issue.sv
// Issue/retire controller for a fixed-latency, non-stallable pipelined adder:
// operand issue, latency-aligned side-band, flag capture and credited buffering.
module blu_add_issue
  import blu_pkg::*;
#(
  parameter int ADD_LAT = 7,
  parameter int DEPTH   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_ci,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  output logic              add_ci,
  input  logic [DATA_W-1:0] add_s,
  input  logic              add_co,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_co,
  output logic              out_ovf,
  output logic              out_zero,
  output logic              out_neg,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int MSB   = DATA_W - 1;

  op_e               op;
  logic [DATA_W-1:0] b_eff;
  logic              ci_eff;
  logic              issue;
  logic              pop;

  logic [DATA_W-1:0] add_a_reg;
  logic [DATA_W-1:0] add_b_reg;
  logic              add_ci_reg;

  logic [CNT_W-1:0]  credits_reg;
  logic [CNT_W-1:0]  credits_next;
  logic              in_ready_reg;

  sb_t               sb_in;
  sb_t               sb_out;
  res_t              cap_res;
  res_t              head_res;
  logic              fifo_wr;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic              unused_fifo_status;

  assign op    = op_e'(in_op);
  assign issue = in_valid && in_ready_reg;
  assign pop   = out_valid && out_ready;

  // Subtraction is A + ~B + carry, so the carry-out reads as "no borrow".
  always_comb begin
    b_eff  = in_b;
    ci_eff = 1'b0;
    case (op)
      OP_ADD: begin b_eff = in_b;  ci_eff = 1'b0;  end
      OP_SUB: begin b_eff = ~in_b; ci_eff = 1'b1;  end
      OP_ADC: begin b_eff = in_b;  ci_eff = in_ci; end
      OP_SBB: begin b_eff = ~in_b; ci_eff = in_ci; end
      default: ;
    endcase
  end

  // Operands only move on a handshake to keep the adder inputs quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a_reg  <= '0;
      add_b_reg  <= '0;
      add_ci_reg <= 1'b0;
    end else if (issue) begin
      add_a_reg  <= in_a;
      add_b_reg  <= b_eff;
      add_ci_reg <= ci_eff;
    end
  end

  assign add_a  = add_a_reg;
  assign add_b  = add_b_reg;
  assign add_ci = add_ci_reg;

  // One credit per operation from issue until its result is popped.
  always_comb begin
    credits_next = credits_reg;
    if (issue && !pop) begin
      credits_next = credits_reg + CNT_W'(1);
    end else if (!issue && pop) begin
      credits_next = credits_reg - CNT_W'(1);
    end
  end

  // Ready is held low through reset, then follows the credit count a cycle
  // later, so a pop frees a slot only from the following cycle on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_reg  <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      credits_reg  <= credits_next;
      in_ready_reg <= (credits_next < CNT_W'(DEPTH));
    end
  end

  assign in_ready = in_ready_reg;

  always_comb begin
    sb_in = '0;
    if (issue) begin
      sb_in.valid  = 1'b1;
      sb_in.tag    = in_tag;
      sb_in.a_sign = in_a[MSB];
      sb_in.b_sign = b_eff[MSB];
    end
  end

  // Stage 0 matches the operand register; the last stage lines up with add_s.
  genvar gi;
  generate
    for (gi = 0; gi <= ADD_LAT; gi++) begin : g_sb
      sb_t stage_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            stage_reg <= '0;
          end else begin
            stage_reg <= sb_in;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            stage_reg <= '0;
          end else begin
            stage_reg <= g_sb[gi-1].stage_reg;
          end
        end
      end
    end
  endgenerate

  assign sb_out = g_sb[ADD_LAT].stage_reg;

  always_comb begin
    cap_res      = '0;
    cap_res.sum  = add_s;
    cap_res.co   = add_co;
    cap_res.ovf  = calc_ovf(sb_out.a_sign, sb_out.b_sign, add_s[MSB]);
    cap_res.zero = (add_s == '0);
    cap_res.neg  = add_s[MSB];
    cap_res.tag  = sb_out.tag;
  end

  assign fifo_wr = sb_out.valid;

  blu_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (cap_res),
    .rd_en   (pop),
    .rd_data (head_res),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  // Credits already bound occupancy; the status outputs are informational.
  assign unused_fifo_status = ^{fifo_full, fifo_count};

  assign out_valid = !fifo_empty;
  assign out_sum   = head_res.sum;
  assign out_co    = head_res.co;
  assign out_ovf   = head_res.ovf;
  assign out_zero  = head_res.zero;
  assign out_neg   = head_res.neg;
  assign out_tag   = head_res.tag;

endmodule

// File: tb/tb_blu_add_issue.sv
// Bench for blu_add_issue with a behavioural fixed-latency adder and an
// in-order scoreboard fed by a reference arithmetic model.
`timescale 1ns/1ps
module tb_blu_add_issue;
  import blu_pkg::*;

  localparam int ADD_LAT = 7;
  localparam int DEPTH   = 16;
  localparam int LAT     = ADD_LAT + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_op = 2'b00;
  logic [DATA_W-1:0] in_a = '0;
  logic [DATA_W-1:0] in_b = '0;
  logic              in_ci = 1'b0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic [DATA_W-1:0] add_a;
  logic [DATA_W-1:0] add_b;
  logic              add_ci;
  logic [DATA_W-1:0] add_s;
  logic              add_co;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_sum;
  logic              out_co;
  logic              out_ovf;
  logic              out_zero;
  logic              out_neg;
  logic [TAG_W-1:0]  out_tag;

  typedef struct {
    res_t r;
    int   issue_cyc;
    bit   lat_chk;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  bit   lat_chk_en = 1'b1;
  int   base;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  blu_add_issue #(
    .ADD_LAT (ADD_LAT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .in_tag    (in_tag),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_s     (add_s),
    .add_co    (add_co),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_co    (out_co),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_tag   (out_tag)
  );

  // Adder stand-in: result appears ADD_LAT cycles after the operands.
  logic [DATA_W:0] adder_pipe [ADD_LAT];
  always @(posedge clk) begin
    adder_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_ci};
    for (int i = 1; i < ADD_LAT; i++) adder_pipe[i] <= adder_pipe[i-1];
  end
  assign {add_co, add_s} = adder_pipe[ADD_LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [1:0] op, input logic [DATA_W-1:0] a,
                                 input logic [DATA_W-1:0] b, input logic ci,
                                 input logic [TAG_W-1:0] tag);
    res_t            r;
    logic            cin;
    logic [DATA_W:0] wide;
    longint          sa, sbv, sr;
    r   = '0;
    cin = (op == 2'b00) ? 1'b0 : (op == 2'b01) ? 1'b1 : ci;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (!op[0]) begin
      wide = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
      r.co = wide[DATA_W];
      sr   = sa + sbv + (cin ? 64'sd1 : 64'sd0);
    end else begin
      wide = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, ~cin};
      r.co = ~wide[DATA_W];
      sr   = sa - sbv - (cin ? 64'sd0 : 64'sd1);
    end
    r.sum  = wide[DATA_W-1:0];
    r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.zero = (r.sum == '0);
    r.neg  = r.sum[DATA_W-1];
    r.tag  = tag;
    return r;
  endfunction

  // Monitor samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        mon_e.r         = model(in_op, in_a, in_b, in_ci, in_tag);
        mon_e.issue_cyc = cyc;
        mon_e.lat_chk   = lat_chk_en;
        sb_q.push_back(mon_e);
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sum",  64'(out_sum),  64'(mon_e.r.sum));
          chk("co",   64'(out_co),   64'(mon_e.r.co));
          chk("ovf",  64'(out_ovf),  64'(mon_e.r.ovf));
          chk("zero", 64'(out_zero), 64'(mon_e.r.zero));
          chk("neg",  64'(out_neg),  64'(mon_e.r.neg));
          chk("tag",  64'(out_tag),  64'(mon_e.r.tag));
          $display("txn tag=%0d sum=0x%08h co=%0b ovf=%0b zero=%0b neg=%0b lat=%0d",
                   out_tag, out_sum, out_co, out_ovf, out_zero, out_neg, cyc - mon_e.issue_cyc);
          if (mon_e.lat_chk) chk("latency", 64'(cyc - mon_e.issue_cyc), 64'(LAT));
        end
      end
      chk("wr_into_full", 64'(dut.fifo_wr && dut.fifo_full), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic ci,
                       input logic [TAG_W-1:0] tag);
    int guard;
    in_op = op; in_a = a; in_b = b; in_ci = ci; in_tag = tag; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("issue_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      step();
      guard++;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
  endtask

  logic [1:0]        d_op  [7] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11};
  logic [DATA_W-1:0] d_a   [7] = '{32'd5, 32'd3, 32'd5, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd10};
  logic [DATA_W-1:0] d_b   [7] = '{32'd7, 32'd5, 32'd5, 32'd1, 32'd1, 32'd0, 32'd3};
  logic              d_ci  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    step(); step();
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_add_a",     64'(add_a),     64'd0);
    chk("rst_add_b",     64'(add_b),     64'd0);
    chk("rst_add_ci",    64'(add_ci),    64'd0);
    chk("rst_out_sum",   64'(out_sum),   64'd0);
    chk("rst_out_tag",   64'(out_tag),   64'd0);
    rst = 1'b0;
    step();
    chk("release_in_ready", 64'(in_ready), 64'd1);

    // Directed arithmetic cases, one at a time so each sees an empty buffer.
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      issue(d_op[k], d_a[k], d_b[k], d_ci[k], (k == 0) ? 4'd3 : 4'(k));
      drain();
    end

    // 20 back-to-back requests at full rate.
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_op = 2'($urandom_range(0, 3)); in_a = $urandom; in_b = $urandom;
      in_ci = 1'($urandom_range(0, 1)); in_tag = 4'(k);
      chk("b2b_in_ready", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 1'b0;
    drain();

    // Fill: downstream stalled, upstream pushing continuously.
    lat_chk_en = 1'b0;
    out_ready = 1'b0;
    base = acc_cnt;
    in_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      in_op = 2'($urandom_range(0, 3)); in_a = $urandom; in_b = $urandom;
      in_ci = 1'($urandom_range(0, 1)); in_tag = 4'(acc_cnt - base);
      step();
    end
    in_valid = 1'b0;
    chk("full_accepted",  64'(acc_cnt - base), 64'(DEPTH));
    chk("full_in_ready",  64'(in_ready),       64'd0);
    chk("full_out_valid", 64'(out_valid),      64'd1);
    out_ready = 1'b1;
    chk("ready_at_first_pop", 64'(in_ready), 64'd0);
    step();
    chk("ready_after_pop", 64'(in_ready), 64'd1);
    drain();

    // Reset with 5 in flight and 2 buffered.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_op = 2'b00; in_a = $urandom; in_b = $urandom; in_ci = 1'b0; in_tag = 4'(8 + k);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_count", 64'(dut.u_fifo.count), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_sum",   64'(out_sum),   64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd0);
    step(); step();
    rst = 1'b0;
    out_ready = 1'b1;
    lat_chk_en = 1'b1;
    step();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (20) step();
    chk("post_rst_no_out", 64'(out_valid), 64'd0);
    issue(2'b00, 32'd1, 32'd1, 1'b0, 4'd5);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
